// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory / print-string arbiter.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [7:0]  NUL_CHAR  = 8'h00;

endpackage

// File: rtl/byte_lane_select.sv
// Big-endian byte extraction from a 32-bit word; offset 0 is the most significant byte.
module byte_lane_select (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    output logic [7:0]  o_byte
);

    always_comb begin
        o_byte = i_word[31:24];
        case (i_offset)
            2'd0: o_byte = i_word[31:24];
            2'd1: o_byte = i_word[23:16];
            2'd2: o_byte = i_word[15:8];
            2'd3: o_byte = i_word[7:0];
            default: o_byte = i_word[31:24];
        endcase
    end

endmodule

// File: rtl/imem_string_arbiter.sv
// Shares the instruction-memory read port between fetch and the print-string engine,
// stalling fetch while a NUL-terminated string is streamed to the console byte by byte.
//
// Console handshake: char_data is presented with char_valid=1 and held unchanged until a
// cycle in which char_ready=1 is sampled on the rising clock edge; that edge transfers it.
module imem_string_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              fetch_stall,
    input  logic              str_start,
    input  logic [ADDR_W-1:0] str_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              str_busy,
    output logic              str_done,
    output logic [LEN_W-1:0]  str_len,
    output logic [1:0]        dbg_state
);

    localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(MAX_LEN - 1);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]  r_cnt;
    logic [7:0]        r_char;
    logic [LEN_W-1:0]  r_str_len;

    logic [7:0]        w_byte;
    logic              w_idle;
    logic              w_unused_ok;

    byte_lane_select u_lane (
        .i_word   (mem_rdata[31:0]),
        .i_offset (r_ptr[1:0]),
        .o_byte   (w_byte)
    );

    // Fetch addresses are word aligned by the port; the low PC bits carry no information here.
    assign w_unused_ok = &{1'b0, fetch_addr[1:0]};

    assign w_idle      = (r_state == ST_IDLE);
    assign mem_addr    = w_idle ? {fetch_addr[ADDR_W-1:2], 2'b00} : {r_ptr[ADDR_W-1:2], 2'b00};
    assign instr       = w_idle ? mem_rdata : DATA_W'(NOP_INSTR);
    assign fetch_stall = !w_idle;
    assign str_busy    = !w_idle;
    assign char_valid  = (r_state == ST_EMIT);
    assign str_done    = (r_state == ST_DONE);
    assign char_data   = r_char;
    assign str_len     = r_str_len;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_char    <= '0;
            r_str_len <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (str_start) begin
                        r_ptr   <= str_addr;
                        r_cnt   <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_char  <= w_byte;
                    r_state <= (w_byte == NUL_CHAR) ? ST_DONE : ST_EMIT;
                end
                ST_EMIT: begin
                    if (char_ready) begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_cnt   <= r_cnt + LEN_W'(1);
                        // Forced termination once MAX_LEN characters have gone out.
                        r_state <= (r_cnt == LAST_CNT) ? ST_DONE : ST_READ;
                    end
                end
                ST_DONE: begin
                    r_str_len <= r_cnt;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
